// File: rtl/sad_tree_acc.sv
// Pipelined radix-4 adder tree summing N_ELEM unsigned elements per beat, with
// optional multi-beat accumulation, saturation, clock-enable stall and flush.
module sad_tree_acc #(
  parameter  int N_ELEM    = 256,
  parameter  int IN_W      = 8,
  parameter  int MAX_BEATS = 16,
  localparam int STAGES    = $clog2(N_ELEM) / 2,
  localparam int SUM_W     = IN_W + 2 * STAGES,
  localparam int ACC_W     = SUM_W + $clog2(MAX_BEATS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic                     in_acc,
  input  logic [N_ELEM*IN_W-1:0]   in_data,
  output logic                     out_valid,
  output logic [ACC_W-1:0]         out_sum,
  output logic                     out_sat
);

  // Tag bit k belongs to data stage k (0 = input register, STAGES = tree root).
  logic [STAGES:0] vld_q, vld_d;
  logic [STAGES:0] last_q, last_d;
  logic [STAGES:0] tacc_q, tacc_d;

  always_comb begin
    vld_d  = vld_q;
    last_d = last_q;
    tacc_d = tacc_q;
    if (ce) begin
      vld_d  = {vld_q[STAGES-1:0], in_valid};
      last_d = {last_q[STAGES-1:0], in_last};
      tacc_d = {tacc_q[STAGES-1:0], in_acc};
      if (flush) vld_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; next-state values
  // come from always_comb blocks that assign a default first, so no latches form.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      last_q <= '0;
      tacc_q <= '0;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
      tacc_q <= tacc_d;
    end
  end

  for (genvar s = 0; s <= STAGES; s++) begin : g_stage
    localparam int W = IN_W + 2 * s;
    localparam int N = N_ELEM >> (2 * s);

    logic [N*W-1:0] data_q, data_d;

    if (s == 0) begin : g_in
      always_comb data_d = ce ? in_data : data_q;
    end else begin : g_tree
      localparam int PW = W - 2;
      // Each node widens by two bits, so the 4-input sum can never overflow.
      always_comb begin
        data_d = data_q;
        if (ce) begin
          for (int j = 0; j < N; j++) begin
            data_d[j*W +: W] =
              ({2'b00, g_stage[s-1].data_q[(4*j+0)*PW +: PW]} +
               {2'b00, g_stage[s-1].data_q[(4*j+1)*PW +: PW]}) +
              ({2'b00, g_stage[s-1].data_q[(4*j+2)*PW +: PW]} +
               {2'b00, g_stage[s-1].data_q[(4*j+3)*PW +: PW]});
          end
        end
      end
    end

    // NOTE: the wide data registers are reset too, so the datapath never carries X.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= data_d;
    end
  end

  logic [SUM_W-1:0] tree_sum;
  assign tree_sum = g_stage[STAGES].data_q;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             acc_open_q, acc_open_d;
  logic             sat_pend_q, sat_pend_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_sat_q, out_sat_d;

  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   new_sum;
  logic             clamp;
  logic [ACC_W-1:0] new_clamped;

  always_comb begin
    base        = acc_open_q ? acc_q : '0;
    new_sum     = {1'b0, base} + {{(ACC_W + 1 - SUM_W){1'b0}}, tree_sum};
    clamp       = new_sum[ACC_W];
    new_clamped = clamp ? {ACC_W{1'b1}} : new_sum[ACC_W-1:0];

    acc_d       = acc_q;
    acc_open_d  = acc_open_q;
    sat_pend_d  = sat_pend_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;

    if (ce) begin
      if (flush) begin
        acc_d       = '0;
        acc_open_d  = 1'b0;
        sat_pend_d  = 1'b0;
        out_valid_d = 1'b0;
      end else if (vld_q[STAGES]) begin
        // A single-beat tag arriving into an open group closes that group.
        if (!tacc_q[STAGES] || last_q[STAGES]) begin
          out_sum_d   = new_clamped;
          out_sat_d   = sat_pend_q | clamp;
          out_valid_d = 1'b1;
          acc_open_d  = 1'b0;
          sat_pend_d  = 1'b0;
        end else begin
          acc_d       = new_clamped;
          acc_open_d  = 1'b1;
          sat_pend_d  = sat_pend_q | clamp;
          out_valid_d = 1'b0;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      acc_open_q  <= 1'b0;
      sat_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      acc_open_q  <= acc_open_d;
      sat_pend_q  <= sat_pend_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_sad_tree_acc.sv
// Self-checking bench for sad_tree_acc at default parameters: expected results
// are queued when a group closes and compared when out_valid appears.
module tb_sad_tree_acc;

  localparam int N_ELEM    = 256;
  localparam int IN_W      = 8;
  localparam int MAX_BEATS = 16;
  localparam int STAGES    = 4;
  localparam int ACC_W     = 20;
  localparam int LAT       = STAGES + 2;
  localparam int DW        = N_ELEM * IN_W;
  localparam logic [ACC_W-1:0] SUM_MAX = 20'd1048575;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ce = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic            in_acc = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            out_valid;
  logic [ACC_W-1:0] out_sum;
  logic            out_sat;

  sad_tree_acc #(.N_ELEM(N_ELEM), .IN_W(IN_W), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .flush(flush),
    .in_valid(in_valid), .in_last(in_last), .in_acc(in_acc), .in_data(in_data),
    .out_valid(out_valid), .out_sum(out_sum), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic             sat;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_e;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   out_cnt = 0;
  bit   en_edge = 1'b0;

  always @(posedge clk) en_edge = ce;

  // Scoreboard: a result is new only on an enabled edge; during stalls it is held.
  always @(negedge clk) begin
    if (rst_n && out_valid && en_edge) begin
      out_cnt++;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_output: out_sum=%0d out_sat=%0b, none expected", out_sum, out_sat);
      end else begin
        exp_e = exp_q.pop_front();
        if (out_sum !== exp_e.sum || out_sat !== exp_e.sat) begin
          tests_failed++;
          $display("FAIL result: got sum=%0d sat=%0b, expected sum=%0d sat=%0b",
                   out_sum, out_sat, exp_e.sum, exp_e.sat);
        end
      end
    end
  end

  function automatic logic [DW-1:0] fill(input logic [7:0] v);
    logic [DW-1:0] d;
    for (int i = 0; i < N_ELEM; i++) d[i*IN_W +: IN_W] = v;
    return d;
  endfunction

  function automatic logic [DW-1:0] ramp();
    logic [DW-1:0] d;
    for (int i = 0; i < N_ELEM; i++) d[i*IN_W +: IN_W] = 8'(i % 256);
    return d;
  endfunction

  function automatic exp_t mk(input logic [ACC_W-1:0] s, input logic sat);
    exp_t e;
    e.sum = s;
    e.sat = sat;
    return e;
  endfunction

  // Caller is aligned 1 time unit after a posedge; returns aligned the same way.
  task automatic send(input logic [DW-1:0] d, input logic acc, input logic last);
    in_data  = d;
    in_valid = 1'b1;
    in_acc   = acc;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_acc   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d results missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (LAT + 2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ce    = 1'b0;
    #12;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid: got %0b, expected 0", out_valid);
    end
    tests_run++;
    if (out_sum !== '0) begin
      tests_failed++;
      $display("FAIL reset_sum: got %0d, expected 0", out_sum);
    end
    tests_run++;
    if (out_sat !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_sat: got %0b, expected 0", out_sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ce = 1'b1;
  endtask

  task automatic test_single_latency();
    int lat;
    bit seen;
    exp_q.push_back(mk(20'd65280, 1'b0));
    send(fill(8'hFF), 1'b0, 1'b0);
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) seen = 1'b1;
    end
    tests_run++;
    if (!seen || lat != LAT) begin
      tests_failed++;
      $display("FAIL single_latency: got %0d cycles (seen=%0b), expected %0d", lat, seen, LAT);
    end
    drain("single");
  endtask

  task automatic test_back_to_back();
    int run;
    bit seen;
    exp_q.push_back(mk(20'd32640, 1'b0));
    exp_q.push_back(mk(20'd256, 1'b0));
    exp_q.push_back(mk(20'd0, 1'b0));
    send(ramp(), 1'b0, 1'b0);
    send(fill(8'h01), 1'b0, 1'b0);
    send(fill(8'h00), 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    run = 0;
    for (int i = 0; i < 6 && out_valid; i++) begin
      run++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (run != 3) begin
      tests_failed++;
      $display("FAIL back_to_back_run: got %0d consecutive valids, expected 3", run);
    end
    drain("back_to_back");
  endtask

  task automatic test_accumulate();
    int c0;
    c0 = out_cnt;
    exp_q.push_back(mk(20'd261120, 1'b0));
    for (int b = 0; b < 4; b++) send(fill(8'hFF), 1'b1, b == 3);
    drain("accumulate");
    tests_run++;
    if (out_cnt - c0 != 1) begin
      tests_failed++;
      $display("FAIL accumulate_count: got %0d outputs, expected 1", out_cnt - c0);
    end
  endtask

  task automatic test_saturation();
    exp_q.push_back(mk(SUM_MAX, 1'b1));
    exp_q.push_back(mk(20'd256, 1'b0));
    for (int b = 0; b < 17; b++) send(fill(8'hFF), 1'b1, b == 16);
    send(fill(8'h01), 1'b0, 1'b0);
    drain("saturation");
  endtask

  task automatic test_stall();
    int  en;
    bit  seen;
    exp_q.push_back(mk(20'd65280, 1'b0));
    ce = 1'b1;
    send(fill(8'hFF), 1'b0, 1'b0);
    en   = 1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      ce = (i % 3 == 2);
      @(posedge clk); #1;
      if (ce) en++;
      if (out_valid) seen = 1'b1;
    end
    tests_run++;
    if (!seen || en != LAT) begin
      tests_failed++;
      $display("FAIL stall_latency: got %0d enabled edges (seen=%0b), expected %0d", en, seen, LAT);
    end
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_sum !== 20'd65280) begin
        tests_failed++;
        $display("FAIL stall_hold: got valid=%0b sum=%0d, expected valid=1 sum=65280", out_valid, out_sum);
      end
    end
    ce = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_release: got valid=%0b, expected 0", out_valid);
    end
    drain("stall");
  endtask

  task automatic test_flush();
    int c0;
    c0 = out_cnt;
    exp_q.push_back(mk(20'd512, 1'b0));
    send(fill(8'hFF), 1'b1, 1'b0);
    send(fill(8'hFF), 1'b1, 1'b0);
    // The beat presented in the flush cycle must be dropped as well.
    flush = 1'b1;
    send(fill(8'h05), 1'b0, 1'b0);
    flush = 1'b0;
    send(fill(8'h02), 1'b0, 1'b0);
    drain("flush");
    tests_run++;
    if (out_cnt - c0 != 1) begin
      tests_failed++;
      $display("FAIL flush_count: got %0d outputs, expected 1", out_cnt - c0);
    end
  endtask

  task automatic test_reset_mid_group();
    int c0;
    c0 = out_cnt;
    send(fill(8'h01), 1'b1, 1'b0);
    send(fill(8'h01), 1'b1, 1'b0);
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (out_valid !== 1'b0 || out_sum !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_group: got valid=%0b sum=%0d, expected 0 0", out_valid, out_sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(mk(20'd768, 1'b0));
    send(fill(8'h03), 1'b0, 1'b0);
    drain("reset_mid_group");
    tests_run++;
    if (out_cnt - c0 != 1) begin
      tests_failed++;
      $display("FAIL reset_mid_group_count: got %0d outputs, expected 1", out_cnt - c0);
    end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_back_to_back();
    test_accumulate();
    test_saturation();
    test_stall();
    test_flush();
    test_reset_mid_group();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sad_tree_acc.md
Name: sad_tree_acc

Overview:
- Parametrised pipelined radix-4 adder tree that sums N_ELEM unsigned elements per beat.
- Optionally accumulates consecutive beats into one result, e.g. a full-macroblock SAD built from partition beats.
- Sits after the absolute-difference stage in the motion-estimation path; successor to the fixed 256x8-bit summer.
- Adds valid/last tagging, clock-enable stall, flush, multi-beat accumulation and saturation.

Parameters:
- N_ELEM, 256: elements per beat; must be a power of 4 and at least 4.
- IN_W, 8: element width in bits.
- MAX_BEATS, 16: accumulation depth the accumulator is sized for.
- Derived (localparam) STAGES = log4(N_ELEM).
- Derived (localparam) SUM_W = IN_W + 2*STAGES.
- Derived (localparam) ACC_W = SUM_W + clog2(MAX_BEATS).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ce  in  1  pipeline clock enable; 0 freezes every register
- flush  in  1  synchronous clear of all valid bits, the accumulator and the open flag
- in_valid  in  1  beat present on in_data
- in_last  in  1  final beat of an accumulation group
- in_acc  in  1  1 = accumulate mode for this beat; 0 = single-beat result
- in_data  in  N_ELEM*IN_W  elements, element i at bits [(i+1)*IN_W-1 : i*IN_W]
- out_valid  out  1  result valid for exactly one cycle
- out_sum  out  ACC_W  result, zero-extended
- out_sat  out  1  result saturated

Behaviour:
- Reset: all pipeline data registers, valid/last/acc tags, accumulator, acc_open, out_valid, out_sum and out_sat go to 0.
- Pipeline: input register, then STAGES radix-4 tree stages, then the accumulator/output stage.
- Stage s register width is IN_W+2s. Each node computes (a+b)+(c+d) at full width with no truncation.
- Tags: valid, last and acc travel alongside the data in every stage.
- Latency: LAT = STAGES+2 enabled cycles from sampling in_valid to out_valid (6 for the defaults).
- Throughput: one beat per enabled cycle.
- ce=0: every register, including tags and out_valid, holds its value. out_valid therefore stays high for as long as ce is low.
- flush=1 with ce=1: all tag valids clear, acc=0, acc_open=0, out_valid=0 on the next edge. Beats in flight are discarded. Data registers may keep stale values.
- flush has priority over in_valid on the same cycle; that cycle's input beat is also dropped.
- flush with ce=0: ignored.
- Output stage rules, evaluated when ce=1 and the tree-output tag is valid (T = tree sum):
  - base = acc if acc_open, else 0.
  - new = base + T, computed with 1 extra bit. If new > 2^ACC_W-1, clamp to 2^ACC_W-1 and set a sticky sat_pend.
  - If tag.acc=0 or tag.last=1: out_sum <= new, out_valid <= 1, out_sat <= (sat_pend or this beat's clamp), then acc_open <= 0 and sat_pend <= 0.
  - Otherwise: acc <= new, acc_open <= 1, out_valid <= 0.
- No valid tag at tree output (with ce=1): out_valid <= 0; out_sum and out_sat hold.
- A tag.acc=0 beat arriving while acc_open=1 is added into the open group and closes it. Callers must not do this, but the behaviour is defined.
- More than MAX_BEATS beats in a group is legal and clamps per the saturation rule.
- Asynchronous reset mid-group discards everything. The first valid beat after reset starts a new group.

Test Plan:
- Defaults, single beat in_acc=0, all elements 0xFF -> out_valid exactly 6 cycles later, out_sum=65280, out_sat=0.
- Back-to-back single beats: ramp element i=i%256 (sum 32640), then all 0x01 (sum 256), then all 0 -> out_valid on 3 consecutive cycles with 32640, 256, 0.
- Accumulate 4 beats of all 0xFF, in_last on the 4th -> exactly one out_valid, out_sum=261120, out_sat=0. out_valid stays 0 during the first 3 beats.
- Accumulate 17 beats of all 0xFF, last on the 17th -> out_sum=1048575, out_sat=1. A following single beat of all 0x01 gives out_sum=256, out_sat=0.
- Single beat of all 0xFF with ce toggling 1,0,0,1,... -> result appears after 6 enabled edges. While ce=0 everything freezes and out_valid is held.
- Open a group with 2 beats of all 0xFF, pulse flush, then send a single beat of all 0x02 -> the only output is out_sum=512; the flushed group never appears.
